// File: rtl/vchip8_onchip_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vchip8_onchip_ram                                            |
// | Description : Avalon-MM single-port on-chip RAM with byte enables, a 1- or |
// |               2-cycle read pipeline, global clock enable and an optional   |
// |               clear engine enabled by VCHIP8_ONCHIP_RAM_CLEAR_EN.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vchip8_onchip_ram #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 14,
    parameter int DEPTH        = 16384,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    input  logic                clken,
    input  logic                clear_req,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest,
    output logic                clear_busy
);

    localparam int c_BYTES = DATA_W / 8;
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0]  r_mem [0:DEPTH-1];
    logic [DATA_W-1:0]  r_rdata;
    logic               r_out_vld;

    logic               w_in_range;
    logic [c_IDX_W-1:0] w_idx;
    logic [DATA_W-1:0]  w_rd_word;
    logic               w_rd_acc;
    logic               w_wr_acc;
    logic               w_pipe_busy;
    logic               w_clr_we;
    logic [c_IDX_W-1:0] w_clr_idx;

    assign w_in_range = ({1'b0, address} < (ADDR_W+1)'(DEPTH));
    assign w_idx      = address[c_IDX_W-1:0];
    assign w_rd_word  = w_in_range ? r_mem[w_idx] : '0;

    assign waitrequest = clear_busy | ~clken;
    // A write wins over a simultaneous read; the read is simply dropped.
    assign w_rd_acc    = chipselect & read & ~write & ~waitrequest;
    assign w_wr_acc    = chipselect & write & ~waitrequest;

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= '0;
        end else if (w_wr_acc && w_in_range) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (byteenable[b]) begin
                    r_mem[w_idx][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_out_vld <= 1'b0;
                    r_rdata   <= '0;
                end else if (clken) begin
                    r_out_vld <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rdata <= w_rd_word;
                    end
                end
            end
            assign w_pipe_busy = r_out_vld;
        end else begin : g_lat2
            logic              r_s1_vld;
            logic [DATA_W-1:0] r_s1_dat;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_s1_vld  <= 1'b0;
                    r_s1_dat  <= '0;
                    r_out_vld <= 1'b0;
                    r_rdata   <= '0;
                end else if (clken) begin
                    r_s1_vld  <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_s1_dat <= w_rd_word;
                    end
                    r_out_vld <= r_s1_vld;
                    if (r_s1_vld) begin
                        r_rdata <= r_s1_dat;
                    end
                end
            end
            assign w_pipe_busy = r_s1_vld | r_out_vld;
        end
    endgenerate

    // Valid is masked while stalled so each read shows exactly one live pulse.
    assign readdata      = r_rdata;
    assign readdatavalid = r_out_vld & clken;

`ifdef VCHIP8_ONCHIP_RAM_CLEAR_EN
    localparam logic [0:0]         c_ST_READY = 1'b0;
    localparam logic [0:0]         c_ST_CLEAR = 1'b1;
    localparam logic [c_IDX_W-1:0] c_LAST     = c_IDX_W'(DEPTH - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_IDX_W-1:0] r_clr_cnt;
    logic [c_IDX_W-1:0] w_clr_cnt_nxt;
    logic               r_clr_pend;
    logic               w_clr_pend_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_ST_CLEAR;
            r_clr_cnt  <= '0;
            r_clr_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_cnt  <= w_clr_cnt_nxt;
            r_clr_pend <= w_clr_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_cnt_nxt  = r_clr_cnt;
        w_clr_pend_nxt = r_clr_pend;
        w_clr_we       = 1'b0;
        case (r_state)
            c_ST_CLEAR: begin
                if (clken) begin
                    w_clr_we = 1'b1;
                    if (r_clr_cnt == c_LAST) begin
                        w_state_nxt   = c_ST_READY;
                        w_clr_cnt_nxt = '0;
                    end else begin
                        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                    end
                end
            end
            default: begin
                // Hold the request until every accepted read has been returned.
                w_clr_pend_nxt = r_clr_pend | clear_req;
                if (clken && w_clr_pend_nxt && !(w_rd_acc || w_pipe_busy)) begin
                    w_state_nxt    = c_ST_CLEAR;
                    w_clr_cnt_nxt  = '0;
                    w_clr_pend_nxt = 1'b0;
                end
            end
        endcase
    end

    assign clear_busy = (r_state == c_ST_CLEAR);
    assign w_clr_idx  = r_clr_cnt;
`else
    logic w_unused_clear;

    assign clear_busy     = 1'b0;
    assign w_clr_we       = 1'b0;
    assign w_clr_idx      = '0;
    assign w_unused_clear = clear_req | w_pipe_busy;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vchip8_onchip_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vchip8_onchip_ram                                         |
// | Description : Self-checking bench; READ_LATENCY 1 and 2 instances side by  |
// |               side against an array model of the RAM contents.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vchip8_onchip_ram;

    localparam int AW  = 8;
    localparam int DEP = 16;

    logic        clk = 1'b0;
    logic        reset_n, chipselect, read, write, clken, clear_req;
    logic [AW-1:0] address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] rdata1, rdata2;
    logic        rdv1, rdv2, wr1, wr2, busy1, busy2;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] model_mem [0:DEP-1];

    always #5 clk = ~clk;

    vchip8_onchip_ram #(.DATA_W(32), .ADDR_W(AW), .DEPTH(DEP), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .clear_req(clear_req), .readdata(rdata1),
        .readdatavalid(rdv1), .waitrequest(wr1), .clear_busy(busy1));

    vchip8_onchip_ram #(.DATA_W(32), .ADDR_W(AW), .DEPTH(DEP), .READ_LATENCY(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .clear_req(clear_req), .readdata(rdata2),
        .readdatavalid(rdv2), .waitrequest(wr2), .clear_busy(busy2));

    function automatic void model_write(input int a, input logic [31:0] d, input logic [3:0] be);
        if (a < DEP) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
            end
        end
    endfunction

    function automatic logic [31:0] model_read(input int a);
        return (a < DEP) ? model_mem[a] : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        clear_req  = 1'b0;
    endtask

    task automatic wait_ready();
        int g = 0;
        while ((wr1 || wr2) && g < 64) begin
            tick();
            g++;
        end
        if (wr1 || wr2) begin
            n_total++;
            $display("FAIL wait_ready: waitrequest=%b%b after %0d cycles, required 00", wr1, wr2, g);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        wait_ready();
        chipselect = 1'b1; write = 1'b1; read = 1'b0;
        address = a; writedata = d; byteenable = be;
        tick();
        idle();
        model_write(int'(a), d, be);
    endtask

    // Issues one read and records, per instance, the cycle of the first valid
    // pulse (accept edge = cycle 0), the data seen with it and the pulse count.
    task automatic read_obs(input logic [AW-1:0] a, output int l1, output int l2,
                            output logic [31:0] d1, output logic [31:0] d2,
                            output int p1, output int p2);
        wait_ready();
        l1 = -1; l2 = -1; d1 = '0; d2 = '0; p1 = 0; p2 = 0;
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
        tick();
        idle();
        for (int k = 1; k <= 6; k++) begin
            #1;
            if (rdv1) begin p1++; if (l1 < 0) begin l1 = k; d1 = rdata1; end end
            if (rdv2) begin p2++; if (l2 < 0) begin l2 = k; d2 = rdata2; end end
            tick();
        end
    endtask

    task automatic test_reset();
        int blen = 0, wbad = 0, exp_len;
        int l1, l2, p1, p2;
        logic [31:0] d1, d2;
        reset_n = 1'b0;
        idle();
        repeat (3) tick();
        n_total += 4;
        if (rdv1 !== 1'b0) $display("FAIL reset_rdv1: got %b required 0", rdv1); else n_pass++;
        if (rdv2 !== 1'b0) $display("FAIL reset_rdv2: got %b required 0", rdv2); else n_pass++;
        if (rdata1 !== 32'h0) $display("FAIL reset_rdata1: got %h required 0", rdata1); else n_pass++;
        if (rdata2 !== 32'h0) $display("FAIL reset_rdata2: got %h required 0", rdata2); else n_pass++;
        reset_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (busy1) begin blen++; if (!wr1) wbad++; end
            tick();
        end
`ifdef VCHIP8_ONCHIP_RAM_CLEAR_EN
        exp_len = DEP;
        for (int i = 0; i < DEP; i++) model_mem[i] = 32'h0;
`else
        exp_len = 0;
        for (int i = 0; i < DEP; i++) do_write(AW'(i), 32'h0, 4'hF);
`endif
        n_total += 2;
        if (blen !== exp_len) $display("FAIL clear_busy_len: got %0d required %0d", blen, exp_len); else n_pass++;
        if (wbad !== 0) $display("FAIL waitreq_during_clear: low in %0d busy cycles, required 0", wbad); else n_pass++;
        read_obs(AW'(5), l1, l2, d1, d2, p1, p2);
        n_total += 4;
        if (d1 !== 32'h0) $display("FAIL post_reset_read1: got %h required 0", d1); else n_pass++;
        if (d2 !== 32'h0) $display("FAIL post_reset_read2: got %h required 0", d2); else n_pass++;
        if (l1 !== 1) $display("FAIL post_reset_lat1: got %0d required 1", l1); else n_pass++;
        if (l2 !== 2) $display("FAIL post_reset_lat2: got %0d required 2", l2); else n_pass++;
    endtask

    task automatic test_byteenable();
        int l1, l2, p1, p2;
        logic [31:0] d1, d2;
        do_write(AW'(3), 32'h0000_0000, 4'hF);
        do_write(AW'(3), 32'hDEAD_BEEF, 4'b0101);
        read_obs(AW'(3), l1, l2, d1, d2, p1, p2);
        n_total += 6;
        if (d1 !== 32'h00AD_00EF) $display("FAIL be_data1: got %h required 00ad00ef", d1); else n_pass++;
        if (d2 !== 32'h00AD_00EF) $display("FAIL be_data2: got %h required 00ad00ef", d2); else n_pass++;
        if (l1 !== 1) $display("FAIL be_lat1: got %0d required 1", l1); else n_pass++;
        if (l2 !== 2) $display("FAIL be_lat2: got %0d required 2", l2); else n_pass++;
        if (p1 !== 1) $display("FAIL be_pulses1: got %0d required 1", p1); else n_pass++;
        if (p2 !== 1) $display("FAIL be_pulses2: got %0d required 1", p2); else n_pass++;
    endtask

    task automatic test_write_first();
        int l1, l2, p1, p2;
        logic [31:0] d1, d2;
        do_write(AW'(7), 32'h1111_1111, 4'hF);
        read_obs(AW'(7), l1, l2, d1, d2, p1, p2);
        n_total += 2;
        if (d1 !== 32'h1111_1111) $display("FAIL wfirst_data1: got %h required 11111111", d1); else n_pass++;
        if (d2 !== 32'h1111_1111) $display("FAIL wfirst_data2: got %h required 11111111", d2); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] s1 [0:7];
        logic [31:0] s2 [0:7];
        int c1 [0:7];
        int c2 [0:7];
        int n1 = 0, n2 = 0;
        for (int i = 0; i < 4; i++) do_write(AW'(10 + i), $urandom, 4'hF);
        for (int k = 0; k < 10; k++) begin
            if (k < 4) begin
                chipselect = 1'b1; read = 1'b1; write = 1'b0; address = AW'(10 + k);
            end else begin
                idle();
            end
            #1;
            if (rdv1 && n1 < 8) begin s1[n1] = rdata1; c1[n1] = k; n1++; end
            if (rdv2 && n2 < 8) begin s2[n2] = rdata2; c2[n2] = k; n2++; end
            tick();
        end
        n_total += 2;
        if (n1 !== 4) $display("FAIL b2b_count1: got %0d required 4", n1); else n_pass++;
        if (n2 !== 4) $display("FAIL b2b_count2: got %0d required 4", n2); else n_pass++;
        for (int i = 0; i < 4 && i < n1 && i < n2; i++) begin
            n_total += 4;
            if (s1[i] !== model_read(10 + i)) $display("FAIL b2b_data1[%0d]: got %h required %h", i, s1[i], model_read(10 + i)); else n_pass++;
            if (s2[i] !== model_read(10 + i)) $display("FAIL b2b_data2[%0d]: got %h required %h", i, s2[i], model_read(10 + i)); else n_pass++;
            if (c1[i] !== i + 1) $display("FAIL b2b_cycle1[%0d]: got %0d required %0d", i, c1[i], i + 1); else n_pass++;
            if (c2[i] !== i + 2) $display("FAIL b2b_cycle2[%0d]: got %0d required %0d", i, c2[i], i + 2); else n_pass++;
        end
        n_total += 2;
        if (rdata1 !== model_read(13)) $display("FAIL held_rdata1: got %h required %h", rdata1, model_read(13)); else n_pass++;
        if (rdata2 !== model_read(13)) $display("FAIL held_rdata2: got %h required %h", rdata2, model_read(13)); else n_pass++;
    endtask

    task automatic test_write_with_read();
        int pulses = 0, l1, l2, p1, p2;
        logic [31:0] d1, d2, v;
        v = $urandom;
        wait_ready();
        chipselect = 1'b1; read = 1'b1; write = 1'b1;
        address = AW'(14); writedata = v; byteenable = 4'hF;
        tick();
        idle();
        model_write(14, v, 4'hF);
        for (int k = 0; k < 4; k++) begin
            #1;
            if (rdv1 || rdv2) pulses++;
            tick();
        end
        read_obs(AW'(14), l1, l2, d1, d2, p1, p2);
        n_total += 3;
        if (pulses !== 0) $display("FAIL wr_rd_no_valid: got %0d pulses required 0", pulses); else n_pass++;
        if (d1 !== v) $display("FAIL wr_rd_data1: got %h required %h", d1, v); else n_pass++;
        if (d2 !== v) $display("FAIL wr_rd_data2: got %h required %h", d2, v); else n_pass++;
    endtask

    task automatic test_clken();
        int l1 = -1, l2 = -1, p1 = 0, p2 = 0, wlow = 0;
        logic [31:0] d1 = '0, d2 = '0;
        do_write(AW'(9), $urandom, 4'hF);
        wait_ready();
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = AW'(9);
        tick();
        idle();
        for (int k = 1; k <= 9; k++) begin
            clken = (k >= 4);
            #1;
            if (k <= 3 && !(wr1 && wr2)) wlow++;
            if (rdv1) begin p1++; if (l1 < 0) begin l1 = k; d1 = rdata1; end end
            if (rdv2) begin p2++; if (l2 < 0) begin l2 = k; d2 = rdata2; end end
            tick();
        end
        clken = 1'b1;
        n_total += 7;
        if (wlow !== 0) $display("FAIL stall_waitreq: low in %0d stalled cycles, required 0", wlow); else n_pass++;
        if (l1 !== 4) $display("FAIL stall_lat1: got %0d required 4", l1); else n_pass++;
        if (l2 !== 5) $display("FAIL stall_lat2: got %0d required 5", l2); else n_pass++;
        if (p1 !== 1) $display("FAIL stall_pulses1: got %0d required 1", p1); else n_pass++;
        if (p2 !== 1) $display("FAIL stall_pulses2: got %0d required 1", p2); else n_pass++;
        if (d1 !== model_read(9)) $display("FAIL stall_data1: got %h required %h", d1, model_read(9)); else n_pass++;
        if (d2 !== model_read(9)) $display("FAIL stall_data2: got %h required %h", d2, model_read(9)); else n_pass++;
    endtask

    task automatic test_out_of_range();
        int l1, l2, p1, p2;
        logic [31:0] d1, d2;
        do_write(AW'(4), $urandom, 4'hF);
        do_write(AW'(20), $urandom, 4'hF);
        read_obs(AW'(4), l1, l2, d1, d2, p1, p2);
        n_total += 2;
        if (d1 !== model_read(4)) $display("FAIL oor_alias1: got %h required %h", d1, model_read(4)); else n_pass++;
        if (d2 !== model_read(4)) $display("FAIL oor_alias2: got %h required %h", d2, model_read(4)); else n_pass++;
        read_obs(AW'(20), l1, l2, d1, d2, p1, p2);
        n_total += 4;
        if (d1 !== 32'h0) $display("FAIL oor_data1: got %h required 0", d1); else n_pass++;
        if (d2 !== 32'h0) $display("FAIL oor_data2: got %h required 0", d2); else n_pass++;
        if (l1 !== 1) $display("FAIL oor_lat1: got %0d required 1", l1); else n_pass++;
        if (l2 !== 2) $display("FAIL oor_lat2: got %0d required 2", l2); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        int spur = 0, l1, l2, p1, p2;
        logic [31:0] d1, d2;
        do_write(AW'(2), 32'h5A5A_1234, 4'hF);
        wait_ready();
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = AW'(2);
        tick();
        idle();
        reset_n = 1'b0;
        #1;
        n_total += 4;
        if (rdv1 !== 1'b0) $display("FAIL midrst_rdv1: got %b required 0", rdv1); else n_pass++;
        if (rdv2 !== 1'b0) $display("FAIL midrst_rdv2: got %b required 0", rdv2); else n_pass++;
        if (rdata1 !== 32'h0) $display("FAIL midrst_rdata1: got %h required 0", rdata1); else n_pass++;
        if (rdata2 !== 32'h0) $display("FAIL midrst_rdata2: got %h required 0", rdata2); else n_pass++;
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 24; k++) begin
            #1;
            if (rdv1 || rdv2) spur++;
            tick();
        end
`ifdef VCHIP8_ONCHIP_RAM_CLEAR_EN
        for (int i = 0; i < DEP; i++) model_mem[i] = 32'h0;
`endif
        n_total++;
        if (spur !== 0) $display("FAIL midrst_spurious: got %0d pulses required 0", spur); else n_pass++;
        read_obs(AW'(2), l1, l2, d1, d2, p1, p2);
        n_total += 2;
        if (d1 !== model_read(2)) $display("FAIL midrst_keep1: got %h required %h", d1, model_read(2)); else n_pass++;
        if (d2 !== model_read(2)) $display("FAIL midrst_keep2: got %h required %h", d2, model_read(2)); else n_pass++;
        read_obs(AW'(20), l1, l2, d1, d2, p1, p2);
        n_total += 2;
        if (l1 !== 1 || d1 !== 32'h0) $display("FAIL midrst_oor1: got lat %0d data %h required lat 1 data 0", l1, d1); else n_pass++;
        if (l2 !== 2 || d2 !== 32'h0) $display("FAIL midrst_oor2: got lat %0d data %h required lat 2 data 0", l2, d2); else n_pass++;
    endtask

    task automatic test_clear();
        int l1 = -1, l2 = -1, b1 = -1, b2 = -1, blen1 = 0, blen2 = 0, p1, p2;
        logic [31:0] d1 = '0, d2 = '0;
        do_write(AW'(1), 32'hA5A5_A5A5, 4'hF);
        wait_ready();
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = AW'(1); clear_req = 1'b1;
        tick();
        idle();
        for (int k = 1; k <= 30; k++) begin
            clear_req = (k == 8);
            #1;
            if (rdv1 && l1 < 0) begin l1 = k; d1 = rdata1; end
            if (rdv2 && l2 < 0) begin l2 = k; d2 = rdata2; end
            if (busy1) begin blen1++; if (b1 < 0) b1 = k; end
            if (busy2) begin blen2++; if (b2 < 0) b2 = k; end
            tick();
        end
        idle();
        n_total += 4;
        if (l1 !== 1 || d1 !== 32'hA5A5_A5A5) $display("FAIL clr_read1: got lat %0d data %h required lat 1 data a5a5a5a5", l1, d1); else n_pass++;
        if (l2 !== 2 || d2 !== 32'hA5A5_A5A5) $display("FAIL clr_read2: got lat %0d data %h required lat 2 data a5a5a5a5", l2, d2); else n_pass++;
`ifdef VCHIP8_ONCHIP_RAM_CLEAR_EN
        if (b1 <= l1) $display("FAIL clr_order1: busy at %0d, required after valid at %0d", b1, l1); else n_pass++;
        if (b2 <= l2) $display("FAIL clr_order2: busy at %0d, required after valid at %0d", b2, l2); else n_pass++;
        n_total += 2;
        if (blen1 !== DEP) $display("FAIL clr_len1: got %0d required %0d", blen1, DEP); else n_pass++;
        if (blen2 !== DEP) $display("FAIL clr_len2: got %0d required %0d", blen2, DEP); else n_pass++;
        for (int i = 0; i < DEP; i++) model_mem[i] = 32'h0;
`else
        if (blen1 !== 0) $display("FAIL clr_ignored1: busy %0d cycles required 0", blen1); else n_pass++;
        if (blen2 !== 0) $display("FAIL clr_ignored2: busy %0d cycles required 0", blen2); else n_pass++;
`endif
        read_obs(AW'(1), l1, l2, d1, d2, p1, p2);
        n_total += 2;
        if (d1 !== model_read(1)) $display("FAIL clr_after1: got %h required %h", d1, model_read(1)); else n_pass++;
        if (d2 !== model_read(1)) $display("FAIL clr_after2: got %h required %h", d2, model_read(1)); else n_pass++;
    endtask

    task automatic test_random();
        int l1, l2, p1, p2, a;
        logic [31:0] d1, d2;
        for (int it = 0; it < 40; it++) begin
            a = int'($urandom_range(0, 23));
            if ($urandom_range(0, 2) != 0) begin
                do_write(AW'(a), $urandom, 4'($urandom_range(0, 15)));
            end else begin
                read_obs(AW'(a), l1, l2, d1, d2, p1, p2);
                n_total += 4;
                if (d1 !== model_read(a)) $display("FAIL rnd_data1 @%0d: got %h required %h", a, d1, model_read(a)); else n_pass++;
                if (d2 !== model_read(a)) $display("FAIL rnd_data2 @%0d: got %h required %h", a, d2, model_read(a)); else n_pass++;
                if (l1 !== 1) $display("FAIL rnd_lat1 @%0d: got %0d required 1", a, l1); else n_pass++;
                if (l2 !== 2) $display("FAIL rnd_lat2 @%0d: got %0d required 2", a, l2); else n_pass++;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; clken = 1'b1; address = '0; byteenable = '0; writedata = '0;
        idle();
        test_reset();
        test_byteenable();
        test_write_first();
        test_back_to_back();
        test_write_with_read();
        test_clken();
        test_out_of_range();
        test_random();
        test_clear();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/vchip8_onchip_ram.md
VCHIP8_ONCHIP_RAM -- requirements
Module: vchip8_onchip_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 14, word-address width.
REQ-003 SHALL have parameter DEPTH, default 16384, number of words, DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter READ_LATENCY, default 1, legal values 1 or 2, cycles from read accept to readdatavalid.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port address, input, ADDR_W, word address.
REQ-008 SHALL have port byteenable, input, DATA_W/8, per-byte write enable.
REQ-009 SHALL have ports chipselect, read and write, inputs, 1 each, Avalon-MM command qualifiers.
REQ-010 SHALL have port writedata, input, DATA_W, write data.
REQ-011 SHALL have port clken, input, 1, global clock enable; low stalls the block.
REQ-012 SHALL have port clear_req, input, 1, single-cycle request to re-zero the memory.
REQ-013 SHALL have ports readdata (output, DATA_W, read data) and readdatavalid (output, 1, readdata qualifier).
REQ-014 SHALL have ports waitrequest (output, 1, command not accepted) and clear_busy (output, 1, clear engine active).

Function
REQ-015 Accept: chipselect & (read|write) & ~waitrequest; waitrequest = clear_busy | ~clken, combinational.
REQ-016 Write with read also high: write performed, read ignored, no readdatavalid generated.
REQ-017 Accepted write: only bytes with byteenable=1 updated, takes effect at that clock edge.
REQ-018 Accepted read: readdatavalid pulses high for one cycle exactly READ_LATENCY clken-high cycles later, with readdata valid in that cycle.
REQ-019 clken low: read pipeline frozen; readdatavalid, readdata and the clear counter hold.
REQ-020 Read of the address just written in the previous cycle returns the new data (write-first).
REQ-021 Back-to-back reads, one per cycle, return data in order with no bubbles.
REQ-022 address >= DEPTH: write ignored; read still produces readdatavalid with readdata = 0.
REQ-023 readdata is held between valid pulses and is not cleared to 0.
REQ-024 Clear FSM states: CLEAR and READY; in CLEAR one word is zeroed per clken-high cycle, counter 0 to DEPTH-1.
REQ-025 CLEAR -> READY after writing word DEPTH-1; clear_busy = (state == CLEAR).
REQ-026 READY -> CLEAR on clear_req=1 only when no reads are in flight; otherwise the request is latched until the pipeline drains.
REQ-027 clear_req during CLEAR is ignored; the counter is not restarted.

Reset
REQ-028 On reset_n low, asynchronously: readdatavalid=0, readdata=0, pipeline emptied, pending clear request cleared.
REQ-029 Reset asserted mid-read discards the read; no readdatavalid is produced for it.
REQ-030 After reset_n rises, the FSM is in CLEAR with counter 0 (macro defined), else READY.
REQ-031 Reset does not clear memory contents except via the clear engine.

Configuration
REQ-032 Macro VCHIP8_ONCHIP_RAM_CLEAR_EN defined: clear engine built per REQ-024..REQ-027 and REQ-030.
REQ-033 Macro VCHIP8_ONCHIP_RAM_CLEAR_EN undefined: no FSM or counter; clear_busy=0; clear_req ignored; contents undefined after power-up.

Verification
REQ-034 Macro defined, DEPTH=16: release reset -> clear_busy high 16 cycles, waitrequest high throughout, then read of address 5 returns 0x00000000.
REQ-035 Write 0xDEADBEEF to address 3 with byteenable=4'b0101 over 0x00000000, then read 3 -> readdata 0x00AD00EF, readdatavalid exactly READ_LATENCY cycles after accept, for both READ_LATENCY=1 and READ_LATENCY=2.
REQ-036 Write 0x11111111 to address 7, read 7 on the next cycle -> 0x11111111; 4 back-to-back reads -> 4 consecutive valid pulses in order.
REQ-037 Read issued, clken low 3 cycles, clken high -> readdatavalid delayed by exactly 3 cycles; waitrequest high while clken is low.
REQ-038 Read in flight with READ_LATENCY=2, reset_n pulsed low -> no readdatavalid; readdata=0 immediately; read of address 20 with DEPTH=16 -> valid with 0.
REQ-039 clear_req with a read in flight -> read completes first, then clear_busy rises; clear_req during CLEAR -> busy length unchanged.
